// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one shift_mul multiplier between NREQ requesters (MUL_ARB_RR_EN selects round-robin)
module mul_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_signed,
  input  logic [NREQ-1:0]      req_hi,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_flush,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [63:0]          resp_data,
  output logic                 mul_valid,
  output logic [1:0]           mul_signed,
  output logic [63:0]          mul_a,
  output logic [63:0]          mul_b,
  output logic                 mul_flush,
  input  logic [63:0]          mul_result_hi,
  input  logic [63:0]          mul_result_lo,
  input  logic                 mul_o_valid,
  output logic                 mul_o_ready
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              hi_q, hi_d;
  logic [1:0]        sgn_q, sgn_d;
  logic [63:0]       a_q, a_d;
  logic [63:0]       b_q, b_d;
  logic [63:0]       resp_data_q, resp_data_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
`ifdef MUL_ARB_RR_EN
  logic [IW-1:0]     ptr_q, ptr_d;
`endif

  logic [NREQ-1:0]   eligible;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic              owner_flush;

  // Pick the winner among requesters that are valid and not being flushed this cycle
  always_comb begin
    eligible    = req_valid & ~req_flush;
    grant_valid = 1'b0;
    grant_idx   = '0;
`ifdef MUL_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_valid && eligible[(int'(ptr_q) + k) % NREQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(i);
      end
    end
`endif
  end

  // Handshake outputs; an owner flush suppresses the multiplier handshake in the same cycle
  always_comb begin
    owner_flush = req_flush[owner_q];
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_valid && (grant_idx == IW'(i));
    end
    mul_valid   = (state_q == ISSUE) && !owner_flush;
    mul_o_ready = (state_q == WAIT) && !owner_flush;
    mul_flush   = ((state_q == ISSUE) || (state_q == WAIT)) && owner_flush;
    mul_a       = a_q;
    mul_b       = b_q;
    mul_signed  = sgn_q;
    resp_data   = resp_data_q;
    resp_valid  = resp_valid_q;
  end

  // Sequencer next-state: latch on grant, issue once, wait for product, hold response
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    hi_d         = hi_q;
    sgn_d        = sgn_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
`ifdef MUL_ARB_RR_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          a_d     = req_a[int'(grant_idx)*64 +: 64];
          b_d     = req_b[int'(grant_idx)*64 +: 64];
          sgn_d   = req_signed[int'(grant_idx)*2 +: 2];
          hi_d    = req_hi[grant_idx];
          state_d = ISSUE;
`ifdef MUL_ARB_RR_EN
          ptr_d   = IW'((int'(grant_idx) + 1) % NREQ);
`endif
        end
      end
      ISSUE: begin
        state_d = owner_flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (owner_flush) begin
          state_d = IDLE;
        end else if (mul_o_valid) begin
          resp_data_d  = hi_q ? mul_result_hi : mul_result_lo;
          resp_valid_d = NREQ'(1) << owner_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (owner_flush || resp_ready[owner_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      hi_q         <= 1'b0;
      sgn_q        <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
`ifdef MUL_ARB_RR_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      hi_q         <= hi_d;
      sgn_q        <= sgn_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
`ifdef MUL_ARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed self-checking bench for mul_arbiter with a shift_mul timing model
module tb_mul_arbiter;

  localparam int NREQ = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_signed;
  logic [NREQ-1:0]     req_hi;
  logic [64*NREQ-1:0]  req_a;
  logic [64*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_flush;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [63:0]         resp_data;
  logic                mul_valid;
  logic [1:0]          mul_signed;
  logic [63:0]         mul_a;
  logic [63:0]         mul_b;
  logic                mul_flush;
  logic [63:0]         mul_result_hi;
  logic [63:0]         mul_result_lo;
  logic                mul_o_valid;
  logic                mul_o_ready;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int flush_cnt = 0;
  bit resp0_seen = 0;
  bit rr1_seen = 0;

  mul_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_hi(req_hi), .req_a(req_a), .req_b(req_b), .req_flush(req_flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_valid(mul_valid), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_flush(mul_flush), .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo),
    .mul_o_valid(mul_o_valid), .mul_o_ready(mul_o_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mul_flush) flush_cnt++;
    if (resp_valid[0]) resp0_seen = 1;
    if (req_ready[1]) rr1_seen = 1;
  end

  // shift_mul model: fresh operands answer at accept+68, repeated operands one cycle after mul_valid
  logic         m_busy;
  int           m_cnt;
  logic [129:0] m_last;
  logic         m_last_v;
  logic [127:0] m_ax, m_bx, m_prod;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; mul_o_valid <= 0; m_cnt <= 0; m_last_v <= 0;
      mul_result_hi <= '0; mul_result_lo <= '0;
    end else if (mul_flush) begin
      m_busy <= 0; mul_o_valid <= 0;
    end else if (mul_o_valid && mul_o_ready) begin
      mul_o_valid <= 0;
    end else if (mul_valid) begin
      m_ax = mul_signed[1] ? {{64{mul_a[63]}}, mul_a} : {64'd0, mul_a};
      m_bx = mul_signed[0] ? {{64{mul_b[63]}}, mul_b} : {64'd0, mul_b};
      m_prod = m_ax * m_bx;
      mul_result_hi <= m_prod[127:64];
      mul_result_lo <= m_prod[63:0];
      m_last <= {mul_signed, mul_a, mul_b};
      m_last_v <= 1;
      if (m_last_v && m_last == {mul_signed, mul_a, mul_b}) begin
        mul_o_valid <= 1; m_busy <= 0;
      end else begin
        m_busy <= 1; m_cnt <= 66;
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        mul_o_valid <= 1; m_busy <= 0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sg, input logic hi);
    req_a[idx*64 +: 64] = a;
    req_b[idx*64 +: 64] = b;
    req_signed[idx*2 +: 2] = sg;
    req_hi[idx] = hi;
  endtask

  // Raise req_valid until accepted; returns accept cycle (or -1) one cycle after accept
  task automatic issue(input int idx, output int acc);
    acc = -1;
    req_valid[idx] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (req_ready[idx]) acc = cyc;
      @(posedge clk); #1;
      if (acc != -1) break;
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_resp(input int idx, input int acc, output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (resp_valid[idx]) begin lat = cyc - acc; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume(input int idx);
    resp_ready[idx] = 1'b1;
    @(posedge clk); #1;
    resp_ready[idx] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, ng, bad;
    int grants[4];
    rst_n = 0; req_valid = '0; req_signed = '0; req_hi = '0; req_a = '0; req_b = '0;
    req_flush = '0; resp_ready = '0;
    step(3);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_o_ready", mul_o_ready, 0);
    chk("rst_mul_flush", mul_flush, 0);
    chk("rst_resp_data", resp_data, 0);
    rst_n = 1;
    step(1);

    // basic low half
    rr1_seen = 0;
    set_op(0, 64'd3, 64'd5, 2'b00, 1'b0);
    issue(0, acc);
    chk("basic_accept", acc != -1, 1);
    wait_resp(0, acc, lat);
    chk("basic_latency", lat, 69);
    chk("basic_data", resp_data, 15);
    chk("basic_resp_onehot", resp_valid, 2'b01);
    consume(0);
    chk("basic_resp_drop", resp_valid, 0);
    chk("basic_no_ready1", rr1_seen, 0);

    // signed high half, then repeated operands
    set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 1'b1);
    issue(1, acc);
    #1;
    chk("sgn_issue_valid", mul_valid, 1);
    chk("sgn_issue_signed", mul_signed, 2'b11);
    chk("sgn_issue_a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_resp(1, acc, lat);
    chk("sgn_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sgn_resp_onehot", resp_valid, 2'b10);
    consume(1);
    issue(1, acc);
    wait_resp(1, acc, lat);
    chk("repeat_latency", lat, 3);
    chk("repeat_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    consume(1);

    // contention: both requesters valid every cycle
    set_op(0, 64'd3, 64'd3, 2'b00, 1'b0);
    set_op(1, 64'd3, 64'd3, 2'b00, 1'b0);
    req_valid = 2'b11; resp_ready = 2'b11;
    ng = 0;
    for (int n = 0; n < 500 && ng < 4; n++) begin
      #1;
      if (req_ready != 0) begin grants[ng] = req_ready[1] ? 1 : 0; ng++; end
      @(posedge clk); #1;
    end
    req_valid = '0;
    step(10);
    resp_ready = '0;
    chk("cont_grant_count", ng, 4);
`ifdef MUL_ARB_RR_EN
    chk("cont_grant0", grants[0], 0);
    chk("cont_grant1", grants[1], 1);
    chk("cont_grant2", grants[2], 0);
    chk("cont_grant3", grants[3], 1);
`else
    chk("cont_grant0", grants[0], 0);
    chk("cont_grant1", grants[1], 0);
    chk("cont_grant2", grants[2], 0);
    chk("cont_grant3", grants[3], 0);
`endif

    // flush in WAIT
    set_op(0, 64'd11, 64'd13, 2'b00, 1'b0);
    issue(0, acc);
    flush_cnt = 0; resp0_seen = 0;
    step(9);
    req_flush[0] = 1'b1;
    #1;
    chk("flush_mul_flush", mul_flush, 1);
    chk("flush_o_ready", mul_o_ready, 0);
    @(posedge clk); #1;
    req_flush[0] = 1'b0;
    #1;
    chk("flush_released", mul_flush, 0);
    set_op(1, 64'd7, 64'd6, 2'b00, 1'b0);
    issue(1, acc);
    wait_resp(1, acc, lat);
    chk("after_flush_data", resp_data, 42);
    consume(1);
    chk("flush_no_resp0", resp0_seen, 0);
    chk("flush_pulse_count", flush_cnt, 1);

    // backpressure then owner flush in RESP
    set_op(0, 64'd9, 64'd9, 2'b00, 1'b0);
    issue(0, acc);
    wait_resp(0, acc, lat);
    chk("bp_data", resp_data, 81);
    set_op(1, 64'd1, 64'd1, 2'b00, 1'b0);
    req_valid[1] = 1'b1;
    flush_cnt = 0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_data !== 64'd81 || req_ready !== 2'b00 || resp_valid !== 2'b01) bad++;
    end
    chk("bp_stable", bad, 0);
    req_flush[0] = 1'b1;
    #1;
    chk("bp_flush_no_mul_flush", mul_flush, 0);
    @(posedge clk); #1;
    req_flush[0] = 1'b0;
    chk("bp_resp_dropped", resp_valid, 0);
    chk("bp_idle_grants_req1", req_ready, 2'b10);
    req_valid[1] = 1'b0;
    #1;
    chk("bp_flush_count", flush_cnt, 0);
    step(2);

    // reset during WAIT
    set_op(0, 64'd100, 64'd3, 2'b00, 1'b0);
    issue(0, acc);
    step(5);
    flush_cnt = 0;
    rst_n = 0;
    @(posedge clk); #1;
    chk("rstw_req_ready", req_ready, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_mul_valid", mul_valid, 0);
    chk("rstw_mul_o_ready", mul_o_ready, 0);
    chk("rstw_mul_flush", mul_flush, 0);
    chk("rstw_resp_data", resp_data, 0);
    chk("rstw_mul_a", mul_a, 0);
    chk("rstw_mul_b", mul_b, 0);
    chk("rstw_mul_signed", mul_signed, 0);
    chk("rstw_flush_count", flush_cnt, 0);
    rst_n = 1;
    step(1);
    set_op(0, 64'd2, 64'd2, 2'b00, 1'b0);
    issue(0, acc);
    wait_resp(0, acc, lat);
    chk("post_rst_data", resp_data, 4);
    chk("post_rst_latency", lat, 69);
    consume(0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Arbiter and sequencer that shares one `shift_mul` iterative multiplier between `NREQ` requesters, such as the integer pipeline MUL/MULH path and a second issue lane. It grants one request at a time, drives the multiplier's valid/flush/output-ready handshake, and returns the selected 64-bit half of the product to the requester that owns the operation. It applies per-requester flush and owner tracking.

## Interface
- `NREQ`, 2, number of requesters (2..4); per-requester buses are packed, requester i at slice i
- `clk` input 1: clock
- `rst_n` input 1: synchronous active-low reset
- `req_valid` input NREQ: request pending
- `req_ready` output NREQ: request accepted this cycle (one-hot or zero)
- `req_signed` input 2*NREQ: {a_signed, b_signed}, passed to `mul_signed`
- `req_hi` input NREQ: 1 = return product[127:64], 0 = product[63:0]
- `req_a`, `req_b` input 64*NREQ: operands
- `req_flush` input NREQ: cancel this requester's request or operation in flight
- `resp_valid` output NREQ: result valid for the owner (one-hot or zero)
- `resp_ready` input NREQ: requester accepts the result
- `resp_data` output 64: result, shared by all requesters
- `mul_valid` output 1; `mul_signed` output 2; `mul_a`, `mul_b` output 64: to the multiplier
- `mul_flush` output 1: to the multiplier
- `mul_result_hi`, `mul_result_lo` input 64; `mul_o_valid` input 1: from the multiplier
- `mul_o_ready` output 1: to the multiplier

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**:
  - Arbitrate among requesters with `req_valid[i] & ~req_flush[i]`.
  - Drive `req_ready` to the winner only.
  - Latch the winner's a, b, signed, hi and owner index, then go to ISSUE.
- **ISSUE**: drive `mul_valid=1` for exactly one cycle from the latched operands, then go to WAIT.
- **WAIT**:
  - Hold `mul_o_ready=1`.
  - When `mul_o_valid=1`, capture `mul_result_hi` if hi, else `mul_result_lo`, into `resp_data` and go to RESP.
  - The multiplier returns to its IDLE on this handshake.
- **RESP**:
  - Hold `resp_valid[owner]=1` and keep `resp_data` stable.
  - On `resp_ready[owner]`, go to IDLE.
- **Owner flush in ISSUE or WAIT**:
  - `mul_flush=1` combinationally in that same cycle.
  - `mul_valid=0`, `mul_o_ready=0`.
  - Go to IDLE; no response is produced.
- **Owner flush in RESP**: drop `resp_valid` and go to IDLE. `mul_flush` is not asserted, because the multiplier is already idle.
- **Non-owner flush**: no effect on the operation in flight. That requester is excluded from the IDLE arbitration in the same cycle.
- **Flush and grant in the same cycle**: the flushed requester is never granted.
- Requests arriving outside IDLE wait; `req_ready` is 0 in every state except IDLE.
- The multiplier's repeated-operand shortcut, where it raises `mul_o_valid` the cycle after `mul_valid`, needs no special handling in WAIT.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready`, `resp_valid`, `mul_valid`, `mul_flush`, `mul_o_ready` = 0
  - `resp_data`, `mul_a`, `mul_b` = 0; `mul_signed` = 0
  - round-robin pointer = 0
- Reset is sampled only at the `clk` edge. Reset mid-operation returns to IDLE without asserting `mul_flush`. The multiplier is reset by the same `rst_n`.
- Request accepted at cycle T (IDLE):
  - `mul_valid` at T+1.
  - If `mul_o_valid` first seen at T+k, `resp_valid` at T+k+1.
  - A new cycle (fresh operands) gives k = 68 with `shift_mul`; a repeated operand set gives k = 2.
- Back-to-back: after `resp_ready` at cycle R, the next grant is at R+1 at the earliest.
- `resp_data` and `resp_valid` are registered. `req_ready` and `mul_flush` are combinational from state and inputs.

## Configuration
- `MUL_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - The pointer advances to owner+1 (mod NREQ) on each grant.
  - The search starts at the pointer.
- Not defined:
  - Fixed priority; the lowest index wins.
  - No pointer register.

## Test plan
- **Basic low half**: req0 a=3, b=5, signed=00, hi=0 → `resp_valid[0]` with `resp_data`=15; `req_ready[1]` stays 0 throughout.
- **Signed high half**: req1 a=-1, b=2, signed=11, hi=1 → `resp_data`=0xFFFF_FFFF_FFFF_FFFF; the same operands reissued → `resp_valid` 3 cycles after accept.
- **Contention**: req0 and req1 valid every cycle.
  - With `MUL_ARB_RR_EN`, grants alternate 0,1,0,1.
  - Without it, req0 is granted every time.
- **Flush in WAIT**: req0 flushed 10 cycles after accept → `mul_flush` pulses one cycle, no `resp_valid`; the next req1 7×6 returns 42.
- **Backpressure and owner flush**: `resp_ready[0]`=0 for 20 cycles → `resp_data` stable and `req_ready`=0; then `req_flush[0]` in RESP → IDLE, `mul_flush` stays 0.
- **Reset**: `rst_n`=0 in WAIT → all outputs 0 next cycle; after release, req0 2×2 → 4.
